// File: rtl/regfile_pkg.sv
// Shared defaults and clear-sequencer state type for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every register index once, issuing one zero-write per cycle.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state;
    logic [ADDR_W-1:0] index;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            index    <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= SWEEP;
                        index    <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Last index is written in this cycle; counter wraps back to 0 on exit.
                    if (index == {ADDR_W{1'b1}}) begin
                        state    <= IDLE;
                        index    <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        index <= index + ADDR_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    index    <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = clr_busy;
    assign clr_addr = index;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read, dual-write register file with hardwired zero and clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en_a,
    input  logic [ADDR_W-1:0]        wr_addr_a,
    input  logic [DATA_W-1:0]        wr_data_a,
    input  logic                     wr_en_b,
    input  logic [ADDR_W-1:0]        wr_addr_b,
    input  logic [DATA_W-1:0]        wr_data_b,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              same_addr;
    logic              a_zero;
    logic              b_zero;
    logic              a_acc;
    logic              b_acc;
    logic              conflict_d;

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write acceptance: sweep blocks both ports, B wins a same-address collision.
    always_comb begin
        same_addr  = (wr_addr_a == wr_addr_b);
        a_zero     = (ZERO_REG != 0) && (wr_addr_a == '0);
        b_zero     = (ZERO_REG != 0) && (wr_addr_b == '0);
        b_acc      = wr_en_b && !clr_we && !b_zero;
        a_acc      = wr_en_a && !clr_we && !a_zero && !(wr_en_b && same_addr);
        conflict_d = wr_en_a && wr_en_b && same_addr && !clr_we;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (a_acc) mem[wr_addr_a] <= wr_data_a;
            if (b_acc) mem[wr_addr_b] <= wr_data_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_conflict <= 1'b0;
        else       wr_conflict <= conflict_d;
    end

    // Read ports; a_acc/b_acc already exclude sweep cycles and the zero register.
    always_comb begin
        rd_data = '0;
        ra      = '0;
        rv      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if (a_acc && (wr_addr_a == ra)) rv = wr_data_a;
            if (b_acc && (wr_addr_b == ra)) rv = wr_data_b;
`endif
            if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
            rd_data[k*DATA_W +: DATA_W] = rv;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (default parameters; follows REGFILE_BYPASS_EN if defined).
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr_en_a;
    logic [ADDR_W-1:0]        wr_addr_a;
    logic [DATA_W-1:0]        wr_data_a;
    logic                     wr_en_b;
    logic [ADDR_W-1:0]        wr_addr_b;
    logic [DATA_W-1:0]        wr_data_b;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     wr_conflict;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en_a     (wr_en_a),
        .wr_addr_a   (wr_addr_a),
        .wr_data_a   (wr_data_a),
        .wr_en_b     (wr_en_b),
        .wr_addr_b   (wr_addr_b),
        .wr_data_b   (wr_data_b),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] port(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic set_ra(input int k, input logic [ADDR_W-1:0] a);
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_en_a   = 1'b1;
        wr_addr_a = a;
        wr_data_a = d;
        cyc();
        wr_en_a   = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int r, input logic [31:0] exp);
        set_ra(0, ADDR_W'(r));
        set_ra(1, ADDR_W'(r));
        #1;
        check_val($sformatf("%s_p0_r%0d", tag, r), port(0), exp);
        check_val($sformatf("%s_p1_r%0d", tag, r), port(1), exp);
    endtask

    initial begin
        reset     = 1'b1;
        rd_addr   = '0;
        wr_en_a   = 1'b0;
        wr_addr_a = '0;
        wr_data_a = '0;
        wr_en_b   = 1'b0;
        wr_addr_b = '0;
        wr_data_b = '0;
        clr_req   = 1'b0;

        // Reset state
        #12;
        check_val("rst_busy", {31'd0, clr_busy}, 32'd0);
        check_val("rst_conf", {31'd0, wr_conflict}, 32'd0);
        set_ra(0, 5'd7);
        #1;
        check_val("rst_rd7", port(0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc();

        // Single write, read sweep on port 0
        wr_a(5'd8, 32'd10);
        for (int r = 0; r < 16; r++) begin
            set_ra(0, ADDR_W'(r));
            #1;
            check_val($sformatf("rd_sweep_r%0d", r), port(0), (r == 8) ? 32'd10 : 32'd0);
        end
        cyc();

        // Hardwired zero: write to addr 0 is dropped and never forwarded
        set_ra(0, 5'd0);
        set_ra(1, 5'd0);
        wr_en_a   = 1'b1;
        wr_addr_a = 5'd0;
        wr_data_a = 32'hFFFF_FFFF;
        #1;
        check_val("zero_same_cyc", port(0), 32'd0);
        cyc();
        wr_en_a = 1'b0;
        check_reg("zero_after", 0, 32'd0);
        cyc();

        // Collision: B wins, conflict pulses one cycle
        wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'd5;
        wr_en_b = 1'b1; wr_addr_b = 5'd3; wr_data_b = 32'd7;
        #1;
        check_val("conf_pre", {31'd0, wr_conflict}, 32'd0);
        cyc();
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        check_val("conf_pulse", {31'd0, wr_conflict}, 32'd1);
        check_reg("coll", 3, 32'd7);
        cyc();
        check_val("conf_drop", {31'd0, wr_conflict}, 32'd0);

        // Collision on the zero register still flags conflict
        wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'd1;
        wr_en_b = 1'b1; wr_addr_b = 5'd0; wr_data_b = 32'd2;
        cyc();
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        check_val("conf_zero", {31'd0, wr_conflict}, 32'd1);
        check_reg("coll_zero", 0, 32'd0);
        cyc();

        // Same-cycle write/read on port 1
        set_ra(1, 5'd12);
        wr_en_b = 1'b1; wr_addr_b = 5'd12; wr_data_b = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_val("byp_same", port(1), 32'h55);
`else
        check_val("byp_same", port(1), 32'h0);
`endif
        cyc();
        wr_en_b = 1'b0;
        #1;
        check_val("byp_next", port(1), 32'h55);
        cyc();

        // Fill 1..31 with index, then clear sweep
        for (int r = 1; r < DEPTH; r++) wr_a(ADDR_W'(r), 32'(r));
        check_reg("fill", 31, 32'd31);
        check_reg("fill", 8, 32'd8);
        cyc();
        clr_req = 1'b1;
        wr_en_a = 1'b1; wr_addr_a = 5'd31; wr_data_a = 32'h1234;
        cyc();
        clr_req = 1'b0;
        wr_en_a = 1'b0;
        check_val("clr_busy_rise", {31'd0, clr_busy}, 32'd1);
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 5) check_reg("sweep_partial", 31, 32'h1234);
            if (cnt == 20) begin
                wr_en_a = 1'b1; wr_addr_a = 5'd1; wr_data_a = 32'hAB;
                wr_en_b = 1'b1; wr_addr_b = 5'd1; wr_data_b = 32'hCD;
            end
            if (cnt == 21) begin
                wr_en_a = 1'b0;
                wr_en_b = 1'b0;
                check_val("sweep_noconf", {31'd0, wr_conflict}, 32'd0);
            end
            cyc();
        end
        check_val("busy_len", cnt, 32'd32);
        wr_a(5'd5, 32'h99);
        for (int r = 0; r < DEPTH; r++) check_reg("post_clr", r, (r == 5) ? 32'h99 : 32'd0);
        cyc();

        // Reset in the middle of a sweep
        for (int r = 1; r < DEPTH; r++) wr_a(ADDR_W'(r), 32'(r));
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (10) cyc();
        check_reg("mid_sweep", 25, 32'd25);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_mid_busy", {31'd0, clr_busy}, 32'd0);
        reset = 1'b0;
        for (int r = 0; r < DEPTH; r++) check_reg("rst_mid", r, 32'd0);
        cyc();
        check_val("rst_mid_idle", {31'd0, clr_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
